// File: rtl/fft_mdc_r2_stage.sv
// fft_mdc_r2_stage: one radix-2 stage of a 2-lane (MDC) pipelined FFT.
// Butterfly -> twiddle multiply with round/saturate -> DEPTH-step commutator, advanced by i_valid.
module fft_mdc_r2_stage #(
    parameter int NBITS       = 10,
    parameter int NBITS_COEFF = 11,
    parameter int DEPTH       = 16,
    parameter int LOG2D       = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_valid,
    input  logic [2*NBITS-1:0]       fftIn_up,
    input  logic [2*NBITS-1:0]       fftIn_down,
    input  logic [2*NBITS_COEFF-1:0] i_coeff,
    output logic [LOG2D:0]           o_coeff_addr,
    output logic [2*(NBITS+2)-1:0]   fftOut_up,
    output logic [2*(NBITS+2)-1:0]   fftOut_down,
    output logic                     o_valid,
    output logic                     o_sof
);
    localparam int AW = NBITS + 1;          // butterfly result width
    localparam int OW = NBITS + 2;          // stage output component width
    localparam int CW = NBITS_COEFF;
    localparam int F  = NBITS_COEFF - 2;    // twiddle fraction bits
    localparam int PW = AW + CW + 2;        // product sum plus rounding headroom
    localparam int XW = LOG2D + 1;          // sample index mod 2*DEPTH
    localparam int WW = LOG2D + 2;

    localparam logic signed [PW-1:0] HALF    = PW'(2 ** (F - 1));
    localparam logic signed [PW-1:0] SAT_MAX = PW'(2 ** (OW - 1) - 1);
    localparam logic signed [PW-1:0] SAT_MIN = PW'(-(2 ** (OW - 1)));
    localparam logic [WW-1:0]        WARM_N  = WW'(DEPTH + 2);

    function automatic logic [OW-1:0] sat(input logic signed [PW-1:0] x);
        if (x > SAT_MAX) return SAT_MAX[OW-1:0];
        if (x < SAT_MIN) return SAT_MIN[OW-1:0];
        return x[OW-1:0];
    endfunction

    // ------------------------------------------------------------------
    // Stage A: butterfly
    // ------------------------------------------------------------------
    logic signed [NBITS-1:0] up_re, up_im, dn_re, dn_im;
    logic signed [AW-1:0]    bf_sr, bf_si, bf_dr, bf_di;
    logic signed [AW-1:0]    a_sr, a_si, a_dr, a_di;
    logic [XW-1:0]           in_cnt;
    logic [XW-1:0]           a_addr;

    assign up_re = fftIn_up[2*NBITS-1:NBITS];
    assign up_im = fftIn_up[NBITS-1:0];
    assign dn_re = fftIn_down[2*NBITS-1:NBITS];
    assign dn_im = fftIn_down[NBITS-1:0];

    // NOTE: combinational blocks use blocking '=' and assign every output on every path,
    // so no latch is inferred; clocked blocks use non-blocking '<=' only.
    always_comb begin
        bf_sr = AW'(up_re) + AW'(dn_re);
        bf_si = AW'(up_im) + AW'(dn_im);
        bf_dr = AW'(up_re) - AW'(dn_re);
        bf_di = AW'(up_im) - AW'(dn_im);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            a_sr   <= '0;
            a_si   <= '0;
            a_dr   <= '0;
            a_di   <= '0;
            a_addr <= '0;
            in_cnt <= '0;
        end else if (i_valid) begin
            a_sr   <= bf_sr;
            a_si   <= bf_si;
            a_dr   <= bf_dr;
            a_di   <= bf_di;
            a_addr <= in_cnt;
            in_cnt <= in_cnt + XW'(1);
        end
    end

    assign o_coeff_addr = a_addr;

    // ------------------------------------------------------------------
    // Stage B: pass-through of the sum, twiddle multiply of the difference
    // ------------------------------------------------------------------
    logic signed [CW-1:0] c_re, c_im;
    logic signed [PW-1:0] m_dr, m_di, m_cr, m_ci;
    logic signed [PW-1:0] acc_re, acc_im;
    logic [OW-1:0]        l_re, l_im, u_re, u_im;
    logic [2*OW-1:0]      b_u, b_l;

    assign c_re = i_coeff[2*CW-1:CW];
    assign c_im = i_coeff[CW-1:0];

    // The half-LSB offset before the arithmetic shift gives round-half-up.
    always_comb begin
        m_dr   = PW'(a_dr);
        m_di   = PW'(a_di);
        m_cr   = PW'(c_re);
        m_ci   = PW'(c_im);
        acc_re = m_dr * m_cr - m_di * m_ci + HALF;
        acc_im = m_dr * m_ci + m_di * m_cr + HALF;
        l_re   = sat(acc_re >>> F);
        l_im   = sat(acc_im >>> F);
        u_re   = OW'(a_sr);
        u_im   = OW'(a_si);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            b_u <= '0;
            b_l <= '0;
        end else if (i_valid) begin
            b_u <= {u_re, u_im};
            b_l <= {l_re, l_im};
        end
    end

    // ------------------------------------------------------------------
    // Commutator and output register
    // ------------------------------------------------------------------
    logic [2*OW-1:0] l_dly [DEPTH];
    logic [2*OW-1:0] p_dly [DEPTH];
    logic [XW-1:0]   step;
    logic            sw;
    logic [2*OW-1:0] l_tail, p_tail, comm_p, comm_q;
    logic [WW-1:0]   warm_cnt;
    logic            warm_done;

    // B lags the input counter by two accepted samples.
    assign step      = in_cnt - XW'(2);
    assign sw        = step[LOG2D];
    assign warm_done = (warm_cnt == WARM_N);

    always_comb begin
        l_tail = l_dly[DEPTH-1];
        p_tail = p_dly[DEPTH-1];
        comm_p = sw ? l_tail : b_u;
        comm_q = sw ? b_u : l_tail;
    end

    // NOTE: the delay lines are explicitly cleared on reset so the first frame after
    // reset never picks up stale samples; this keeps them in flops rather than RAM.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                l_dly[i] <= '0;
                p_dly[i] <= '0;
            end
        end else if (i_valid) begin
            l_dly[0] <= b_l;
            p_dly[0] <= comm_p;
            for (int i = 1; i < DEPTH; i++) begin
                l_dly[i] <= l_dly[i-1];
                p_dly[i] <= p_dly[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fftOut_up   <= '0;
            fftOut_down <= '0;
            o_valid     <= 1'b0;
            o_sof       <= 1'b0;
            warm_cnt    <= '0;
        end else begin
            o_valid <= i_valid && warm_done;
            o_sof   <= i_valid && warm_done && (step == XW'(DEPTH));
            if (i_valid) begin
                fftOut_up   <= p_tail;
                fftOut_down <= comm_q;
                if (!warm_done) warm_cnt <= warm_cnt + WW'(1);
            end
        end
    end

endmodule

// File: tb/tb_fft_mdc_r2_stage.sv
// Directed-vector bench for fft_mdc_r2_stage at DEPTH=2: reset, ramp stream, stalls,
// saturation/rounding corners and mid-frame reset.
module tb_fft_mdc_r2_stage;
    localparam int NBITS       = 10;
    localparam int NBITS_COEFF = 11;
    localparam int DEPTH       = 2;
    localparam int LOG2D       = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_valid = 1'b0;
    logic [19:0] fftIn_up = '0;
    logic [19:0] fftIn_down = '0;
    logic [21:0] i_coeff = '0;
    logic [1:0]  o_coeff_addr;
    logic [23:0] fftOut_up, fftOut_down;
    logic        o_valid, o_sof;

    always #5 clk = ~clk;

    fft_mdc_r2_stage #(
        .NBITS(NBITS), .NBITS_COEFF(NBITS_COEFF), .DEPTH(DEPTH), .LOG2D(LOG2D)
    ) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid),
        .fftIn_up(fftIn_up), .fftIn_down(fftIn_down), .i_coeff(i_coeff),
        .o_coeff_addr(o_coeff_addr), .fftOut_up(fftOut_up), .fftOut_down(fftOut_down),
        .o_valid(o_valid), .o_sof(o_sof)
    );

    typedef struct {
        logic        valid;
        logic [19:0] up;
        logic [19:0] down;
        logic [21:0] coeff;
        logic        e_valid;
        logic        e_sof;
        logic [1:0]  e_addr;
        logic [23:0] e_up;
        logic [23:0] e_down;
    } vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t t2 [10];
    vec_t t4 [8];

    function automatic vec_t mk(int ur, int ui, int dr, int di, int cr, int ci,
                                logic ev, logic es, int ea,
                                int eur, int eui, int edr, int edi);
        vec_t v;
        v.valid   = 1'b1;
        v.up      = {ur[9:0], ui[9:0]};
        v.down    = {dr[9:0], di[9:0]};
        v.coeff   = {cr[10:0], ci[10:0]};
        v.e_valid = ev;
        v.e_sof   = es;
        v.e_addr  = ea[1:0];
        v.e_up    = {eur[11:0], eui[11:0]};
        v.e_down  = {edr[11:0], edi[11:0]};
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input logic rst_val, input string tag);
        @(negedge clk);
        rst        = rst_val;
        i_valid    = v.valid;
        fftIn_up   = v.up;
        fftIn_down = v.down;
        i_coeff    = v.coeff;
        @(posedge clk);
        #1;
        check({tag, " o_valid"}, 32'(o_valid), 32'(v.e_valid));
        check({tag, " o_sof"}, 32'(o_sof), 32'(v.e_sof));
        check({tag, " addr"}, 32'(o_coeff_addr), 32'(v.e_addr));
        check({tag, " out_up"}, 32'(fftOut_up), 32'(v.e_up));
        check({tag, " out_down"}, 32'(fftOut_down), 32'(v.e_down));
    endtask

    // Reset with i_valid high and junk data: reset must win, everything reads zero.
    task automatic do_reset(input string tag);
        vec_t v;
        v        = mk(0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 0, 0, 0, 0, 0);
        v.up     = 20'($urandom);
        v.down   = 20'($urandom);
        v.coeff  = 22'($urandom);
        apply(v, 1'b0, tag);
    endtask

    initial begin
        int e_up_re [10] = '{0, 0, 0, 0, 1, 2, 1, 2, 5, 6};
        int e_dn_re [10] = '{0, 0, 0, 0, 3, 4, 3, 4, 7, 8};
        vec_t idle;

        // Ramp stream: up.re = n+1, twiddle = +1.0
        for (int n = 0; n < 10; n++)
            t2[n] = mk(n + 1, 0, 0, 0, 512, 0, n >= 4, (n == 4) || (n == 8), n % 4,
                       e_up_re[n], 0, e_dn_re[n], 0);

        // Saturation and rounding corners; row n's coeff multiplies sample n-1
        t4[0] = mk(511, 511, -512, -512, 0, 0,     1'b0, 1'b0, 0, 0, 0, 0, 0);
        t4[1] = mk(1, 0, 0, 0, 1023, -1024,        1'b0, 1'b0, 1, 0, 0, 0, 0);
        t4[2] = mk(1, 0, 0, 0, 256, 0,             1'b0, 1'b0, 2, 0, 0, 0, 0);
        t4[3] = mk(0, 0, 1, 0, 255, 0,             1'b0, 1'b0, 3, 0, 0, 0, 0);
        t4[4] = mk(0, 0, 0, 0, 256, 0,             1'b1, 1'b1, 0, -1, -1, 1, 0);
        t4[5] = mk(0, 0, 0, 0, 0, 0,               1'b1, 1'b0, 1, 1, 0, 1, 0);
        t4[6] = mk(0, 0, 0, 0, 0, 0,               1'b1, 1'b0, 2, 2047, -2, 0, 0);
        t4[7] = mk(0, 0, 0, 0, 0, 0,               1'b1, 1'b0, 3, 1, 0, 0, 0);

        for (int i = 0; i < 3; i++) do_reset($sformatf("reset c%0d", i));

        for (int n = 0; n < 10; n++) apply(t2[n], 1'b1, $sformatf("ramp n%0d", n));

        do_reset("reset before stall");
        for (int n = 0; n < 10; n++) begin
            apply(t2[n], 1'b1, $sformatf("stall n%0d", n));
            idle         = t2[n];
            idle.valid   = 1'b0;
            idle.e_valid = 1'b0;
            idle.e_sof   = 1'b0;
            idle.up      = 20'($urandom);
            idle.down    = 20'($urandom);
            apply(idle, 1'b1, $sformatf("stall idle n%0d", n));
        end

        do_reset("reset before corners");
        for (int n = 0; n < 8; n++) apply(t4[n], 1'b1, $sformatf("corner n%0d", n));

        do_reset("reset before restart");
        for (int n = 0; n < 6; n++) apply(t2[n], 1'b1, $sformatf("pre-abort n%0d", n));
        do_reset("mid-frame reset");
        for (int n = 0; n < 10; n++) apply(t2[n], 1'b1, $sformatf("restart n%0d", n));

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
